// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared types and default sizing for the up/down sweep controller.
package updown_sweep_ctrl_pkg;

  localparam int unsigned DEF_WIDTH    = 3;
  localparam int unsigned DEF_NREQ     = 2;
  localparam int unsigned DEF_NSWEEP_W = 4;
  localparam int unsigned STATE_W      = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_UP   = 2'd1;
  localparam state_t ST_DOWN = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/updown_sweep_ctrl_if.sv
// Requester/consumer-facing bus of the sweep controller.
interface updown_sweep_ctrl_if #(
  parameter int unsigned WIDTH    = updown_sweep_ctrl_pkg::DEF_WIDTH,
  parameter int unsigned NREQ     = updown_sweep_ctrl_pkg::DEF_NREQ,
  parameter int unsigned NSWEEP_W = updown_sweep_ctrl_pkg::DEF_NSWEEP_W
) ();

  localparam int unsigned IDXW = updown_sweep_ctrl_pkg::idx_w(NREQ);

  logic [NREQ-1:0]          req;
  logic [NREQ*WIDTH-1:0]    req_lo;
  logic [NREQ*WIDTH-1:0]    req_hi;
  logic [NREQ*NSWEEP_W-1:0] req_n;
  logic                     abort;
  logic [NREQ-1:0]          gnt;
  logic [IDXW-1:0]          owner;
  logic                     busy;
  logic                     up_down;
  logic [WIDTH-1:0]         count;
  logic                     done;
  logic                     err;

  modport master (
    output req, req_lo, req_hi, req_n, abort,
    input  gnt, owner, busy, up_down, count, done, err
  );

  modport slave (
    input  req, req_lo, req_hi, req_n, abort,
    output gnt, owner, busy, up_down, count, done, err
  );

endinterface

// File: rtl/sweep_rr_arbiter.sv
// Round-robin pick: first asserted request at or after rr_ptr, wrapping.
module sweep_rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDXW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] index,
  output logic            valid
);

  logic [IDXW-1:0] cand;

  // Scan from the pointer outward; the first hit wins.
  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDXW'((32'(rr_ptr) + 32'(k)) % NREQ);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        index       = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer sharing one up/down counter between requesters.
module updown_sweep_ctrl
  import updown_sweep_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned NREQ     = DEF_NREQ,
  parameter int unsigned NSWEEP_W = DEF_NSWEEP_W
) (
  input logic                clk,
  input logic                rstn,
  updown_sweep_ctrl_if.slave bus
);

  localparam int unsigned IDXW = idx_w(NREQ);

  state_t              state, state_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [NSWEEP_W-1:0] sweeps_q, sweeps_d;
  logic                up_down_q, up_down_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [IDXW-1:0]     owner_q, owner_d;
  logic [IDXW-1:0]     rr_ptr, rr_ptr_d;

  logic [NREQ-1:0]     arb_grant;
  logic [IDXW-1:0]     arb_idx;
  logic                arb_valid;
  logic [WIDTH-1:0]    sel_lo, sel_hi;
  logic [NSWEEP_W-1:0] sel_n;

  // A request still high during its own grant pulse must not be re-granted.
  sweep_rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
    .req    (bus.req & ~gnt_q),
    .rr_ptr (rr_ptr),
    .grant  (arb_grant),
    .index  (arb_idx),
    .valid  (arb_valid)
  );

  // Select the winning requester's configuration slice.
  always_comb begin
    sel_lo = '0;
    sel_hi = '0;
    sel_n  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IDXW'(i)) begin
        sel_lo = bus.req_lo[i*WIDTH +: WIDTH];
        sel_hi = bus.req_hi[i*WIDTH +: WIDTH];
        sel_n  = bus.req_n[i*NSWEEP_W +: NSWEEP_W];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    count_d   = count_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    sweeps_d  = sweeps_q;
    up_down_d = up_down_q;
    busy_d    = busy_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr;
    gnt_d     = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d    = arb_grant;
          owner_d  = arb_idx;
          rr_ptr_d = IDXW'((32'(arb_idx) + 32'd1) % NREQ);
          lo_d     = sel_lo;
          hi_d     = sel_hi;
          if ((sel_lo < sel_hi) && (sel_n != '0)) begin
            count_d   = sel_lo;
            up_down_d = 1'b1;
            sweeps_d  = sel_n;
            busy_d    = 1'b1;
            state_d   = ST_UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_UP: begin
        if (bus.abort) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          up_down_d = 1'b1;
        end else if (count_q == hi_q) begin
          count_d   = hi_q - WIDTH'(1);
          up_down_d = 1'b0;
          state_d   = ST_DOWN;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      ST_DOWN: begin
        if (bus.abort) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          up_down_d = 1'b1;
        end else if (count_q != lo_q) begin
          count_d = count_q - WIDTH'(1);
        end else if (sweeps_q == NSWEEP_W'(1)) begin
          sweeps_d  = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          up_down_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          sweeps_d  = sweeps_q - NSWEEP_W'(1);
          count_d   = lo_q + WIDTH'(1);
          up_down_d = 1'b1;
          state_d   = ST_UP;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset is asynchronous, active-high.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state     <= ST_IDLE;
      count_q   <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      sweeps_q  <= '0;
      up_down_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      gnt_q     <= '0;
      owner_q   <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_d;
      count_q   <= count_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      sweeps_q  <= sweeps_d;
      up_down_q <= up_down_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      rr_ptr    <= rr_ptr_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.up_down = up_down_q;
  assign bus.count   = count_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed plus randomized bench for updown_sweep_ctrl against a trajectory model.
module tb_updown_sweep_ctrl;

  localparam int unsigned WIDTH    = 3;
  localparam int unsigned NREQ     = 2;
  localparam int unsigned NSWEEP_W = 4;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  updown_sweep_ctrl_if #(.WIDTH(WIDTH), .NREQ(NREQ), .NSWEEP_W(NSWEEP_W)) bus ();

  updown_sweep_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .NSWEEP_W(NSWEEP_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Requester-side model state.
  int       lo_c [2];
  int       hi_c [2];
  int       n_c  [2];
  int       ab_c [2];
  bit [1:0] pending;
  int       rr_m;
  int       model_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    bus.req = pending;
    for (int i = 0; i < 2; i++) begin
      bus.req_lo[i*3 +: 3] = 3'(lo_c[i]);
      bus.req_hi[i*3 +: 3] = 3'(hi_c[i]);
      bus.req_n[i*4 +: 4]  = 4'(n_c[i]);
    end
  endtask

  function automatic bit cfg_ok(input int r);
    return (lo_c[r] < hi_c[r]) && (n_c[r] != 0);
  endfunction

  function automatic int pick(input bit [1:0] p, input int rr);
    for (int k = 0; k < 2; k++) begin
      if (p[(rr + k) % 2]) return (rr + k) % 2;
    end
    return -1;
  endfunction

  // Expected counter path: first sweep lo..hi..lo, later sweeps lo+1..hi..lo.
  task automatic run_traj(input int r);
    int lo, hi, n, ab;
    int qc[$];
    bit qd[$];
    lo = lo_c[r]; hi = hi_c[r]; n = n_c[r]; ab = ab_c[r];
    for (int s = 0; s < n; s++) begin
      for (int v = (s == 0) ? lo : lo + 1; v <= hi; v++) begin
        qc.push_back(v); qd.push_back(1'b1);
      end
      for (int v = hi - 1; v >= lo; v--) begin
        qc.push_back(v); qd.push_back(1'b0);
      end
    end
    for (int e = 0; e < qc.size(); e++) begin
      if (e > 0) begin
        tick();
        chk("gnt_quiet", bus.gnt, 0);
      end
      chk("count", bus.count, qc[e]);
      chk("up_down", bus.up_down, qd[e]);
      chk("busy", bus.busy, 1);
      chk("done_early", bus.done, 0);
      if (e == ab) begin
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_count", bus.count, qc[e]);
        chk("abort_up_down", bus.up_down, 1);
        chk("abort_no_done", bus.done, 0);
        model_count = qc[e];
        return;
      end
    end
    tick();
    chk("done", bus.done, 1);
    chk("done_busy", bus.busy, 0);
    chk("done_up_down", bus.up_down, 1);
    chk("done_count", bus.count, lo);
    chk("done_gnt", bus.gnt, 0);
    tick();
    chk("done_pulse", bus.done, 0);
    chk("no_gnt_in_done", bus.gnt, 0);
    chk("idle_busy", bus.busy, 0);
    model_count = lo;
  endtask

  // Wait for the next grant, then follow the granted transaction to its end.
  task automatic serve();
    int  w;
    bit  got;
    w   = pick(pending, rr_m);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (bus.gnt != 0) got = 1'b1;
      else chk("idle_no_done", bus.done, 0);
    end
    if (!got) begin
      chk("gnt_timeout", bus.gnt, 1 << w);
      pending = '0;
      drive();
      return;
    end
    chk("gnt", bus.gnt, 1 << w);
    chk("owner", bus.owner, w);
    pending[w] = 1'b0;
    rr_m = (w + 1) % 2;
    drive();
    if (cfg_ok(w)) begin
      chk("err_clear", bus.err, 0);
      run_traj(w);
    end else begin
      chk("err", bus.err, 1);
      chk("rej_busy", bus.busy, 0);
      chk("rej_count", bus.count, model_count);
    end
  endtask

  task automatic set_cfg(input int r, input int lo, input int hi, input int n, input int ab);
    lo_c[r] = lo; hi_c[r] = hi; n_c[r] = n; ab_c[r] = ab;
  endtask

  task automatic gen(input int r);
    if ($urandom % 4 != 0) begin
      lo_c[r] = int'($urandom_range(0, 6));
      hi_c[r] = int'($urandom_range(32'(lo_c[r] + 1), 7));
      n_c[r]  = int'($urandom_range(1, 3));
    end else begin
      lo_c[r] = int'($urandom % 8);
      hi_c[r] = int'($urandom % 8);
      n_c[r]  = int'($urandom % 4);
    end
    ab_c[r] = -1;
    if (cfg_ok(r) && ($urandom % 5 == 0))
      ab_c[r] = int'($urandom % 32'(2 * (hi_c[r] - lo_c[r]) * n_c[r] + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r;
    rstn = 1'b1;
    bus.abort = 1'b0;
    pending = '0;
    rr_m = 0;
    model_count = 0;
    for (int i = 0; i < 2; i++) set_cfg(i, 0, 0, 0, -1);
    drive();
    #12;
    chk("rst_count", bus.count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_up_down", bus.up_down, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    @(negedge clk);
    rstn = 1'b0;

    // Both requesters at once from rr_ptr=0: 0 first, then 1.
    set_cfg(0, 2, 3, 1, -1);
    set_cfg(1, 0, 2, 1, -1);
    pending = 2'b11;
    drive();
    serve();
    serve();

    // Single triangle 1..4..1.
    set_cfg(0, 1, 4, 1, -1);
    pending = 2'b01;
    drive();
    serve();

    // Rejected configurations: empty range, then zero sweeps.
    set_cfg(1, 5, 5, 1, -1);
    pending = 2'b10;
    drive();
    serve();
    set_cfg(1, 1, 2, 0, -1);
    pending = 2'b10;
    drive();
    serve();

    // Full range, two triangles, no wrap.
    set_cfg(0, 0, 7, 2, -1);
    pending = 2'b01;
    drive();
    serve();

    // Abort on the cycle the last sweep returns to lo.
    set_cfg(1, 2, 5, 1, 6);
    pending = 2'b10;
    drive();
    serve();

    // Asynchronous reset while counting up at 3.
    set_cfg(0, 1, 5, 1, -1);
    pending = 2'b01;
    drive();
    tick();
    chk("pre_rst_gnt", bus.gnt, 1 << pick(2'b01, rr_m));
    pending = '0;
    drive();
    tick();
    tick();
    chk("pre_rst_count", bus.count, 3);
    rstn = 1'b1;
    #1;
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_gnt", bus.gnt, 0);
    chk("mid_rst_up_down", bus.up_down, 1);
    @(negedge clk);
    rstn = 1'b0;
    rr_m = 0;
    model_count = 0;

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      if (pending != 2'b11 && (pending == 2'b00 || ($urandom % 2) == 1)) begin
        if (pending[0])      r = 1;
        else if (pending[1]) r = 0;
        else                 r = int'($urandom % 2);
        gen(r);
        pending[r] = 1'b1;
      end
      drive();
      serve();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
